multi_channel_master_slave_sampler: RTL and testbench
=====================================================

// Module: multi_channel_master_slave_sampler
// PURPOSE
//  Generalised master-slave sampler: NUM_CH blocking data inputs, each with its own sync flag, feeding one output.
//  Channels are served round-robin by a two-section FSM: first wait/sample, then publish.
//  Adds an optional accumulate mode and a per-channel wait timeout with a sticky error flag.
//  Sits between producer slaves and a single consumer; the output is a valid-qualified registered stream.
// PARAMETERS
//  NUM_CH     2     number of input channels (>=1); CH_W = max(1,$clog2(NUM_CH))
//  DATA_W     32    data width of every channel and of s_out
//  RESET_VAL  1337  reset value of internal val register and of s_out
//  ACCUM      0     0: val <= sample; 1: val <= val + sample, modulo 2**DATA_W
//  TIMEOUT    0     cycles to wait for sync before skipping a channel; 0 disables timeout
// PORTS
//  clk          in   1              clock, all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  s_in         in   NUM_CH*DATA_W  channel k data at [k*DATA_W +: DATA_W]
//  s_in_sync    in   NUM_CH         bit k high: s_in channel k holds a valid value this cycle
//  err_clr      in   1              clears timeout_err
//  s_out        out  DATA_W         last published value (registered)
//  s_out_valid  out  1              one-cycle pulse: s_out/s_out_ch updated this cycle
//  s_out_ch     out  CH_W           channel index that produced s_out
//  timeout_err  out  1              sticky: a channel was skipped by timeout
//  section      out  1              debug: 0 = SECTION_A, 1 = SECTION_B
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   section=A, ch=0, timer=0, val=RESET_VAL, s_out=RESET_VAL, s_out_ch=0, s_out_valid=0, timeout_err=0.
//   Reset overrides every other input.
//  SECTION_A (sample), serving channel ch:
//   - s_in_sync[ch]=1: val <= ACCUM ? val+s_in[ch] : s_in[ch]; timer <= 0; next section B.
//   - Sync low, TIMEOUT!=0, timer==TIMEOUT-1: skip the channel.
//     ch <= (ch==NUM_CH-1) ? 0 : ch+1; timer <= 0; timeout_err <= 1; stay A; no output.
//   - Otherwise timer <= timer+1 (when TIMEOUT!=0); stay A.
//   - Sync bits of channels other than ch are ignored (not buffered).
//   - Sync high on the cycle the timer expires: sampling wins, no error.
//  SECTION_B (publish), one cycle:
//   - s_out <= val; s_out_ch <= ch; s_out_valid <= 1.
//   - ch <= ch+1, wrapping at NUM_CH; next section A.
//   - All sync inputs are ignored in B.
//  Other outputs:
//   - s_out_valid is 0 on every cycle that does not follow a B cycle.
//   - s_out holds its value between pulses.
//  Latency: sync seen at edge t -> s_out_valid high in cycle after edge t+1 (2 edges).
//   Maximum throughput is one output per 2 cycles.
//  err_clr: clears timeout_err; if a timeout occurs in the same cycle, set wins.
//  Widths: the add wraps silently, no saturation. timer is wide enough for TIMEOUT-1.
//  NUM_CH=1: ch stays 0, wrap is a no-op.
// TESTING (NUM_CH=2, DATA_W=32 unless noted)
//  1 reset: rst high 2 cycles, then low -> s_out=1337, s_out_valid=0, s_out_ch=0, section=0, timeout_err=0.
//  2 sample: sync[0]=1, s_in ch0=5 for 1 cycle -> 2 edges later valid=1 for 1 cycle, s_out=5, ch=0;
//    then sync[1]=1, data 9 -> s_out=9, s_out_ch=1.
//  3 ignore: waiting on ch0, pulse sync[1] with data 7 -> no valid; next, sync[0] with data 3 -> s_out=3, ch=0.
//  4 timeout (TIMEOUT=4): no sync for 4 cycles -> timeout_err=1, no valid, section=0;
//    sync[1] data 8 -> s_out=8, ch=1; err_clr -> timeout_err=0.
//  5 accumulate (ACCUM=1): from reset, ch0 data 10 -> s_out=1347;
//    then ch1 data 32'hFFFFFFFF -> s_out=1346 (wrap).
//  6 reset mid-op: assert rst during section B -> no valid pulse, s_out=1337, next sample is served from ch0.

Source files
------------

// File: rtl/multi_channel_master_slave_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_channel_master_slave_sampler                                       |
// | Round-robin sampler: waits for each channel's sync, then publishes it.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module multi_channel_master_slave_sampler #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int RESET_VAL = 1337,
  parameter int ACCUM     = 0,
  parameter int TIMEOUT   = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        s_out,
  output logic                     s_out_valid,
  output logic [CH_W-1:0]          s_out_ch,
  output logic                     timeout_err,
  output logic                     section
);

  localparam int                c_tmr_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DATA_W-1:0] c_reset_val = DATA_W'(RESET_VAL);
  localparam logic [CH_W-1:0]   c_last_ch   = CH_W'(NUM_CH - 1);
  localparam logic [c_tmr_w-1:0] c_timer_max = c_tmr_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } section_t;

  section_t           r_section;
  logic [CH_W-1:0]    r_ch;
  logic [c_tmr_w-1:0] r_timer;
  logic [DATA_W-1:0]  r_val;
  logic [DATA_W-1:0]  r_out;
  logic [CH_W-1:0]    r_out_ch;
  logic               r_out_valid;
  logic               r_err;

  logic [DATA_W-1:0]  w_sample;
  logic               w_sync;
  logic [CH_W-1:0]    w_ch_next;
  logic               w_timeout_hit;

  assign w_sample      = s_in[int'(r_ch)*DATA_W +: DATA_W];
  assign w_sync        = s_in_sync[r_ch];
  assign w_ch_next     = (r_ch == c_last_ch) ? '0 : r_ch + CH_W'(1);
  assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == c_timer_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_section   <= SECTION_A;
      r_ch        <= '0;
      r_timer     <= '0;
      r_val       <= c_reset_val;
      r_out       <= c_reset_val;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (err_clr) r_err <= 1'b0;
      unique case (r_section)
        SECTION_A: begin
          // Sampling beats an expiring timer on the same cycle.
          if (w_sync) begin
            r_val     <= (ACCUM != 0) ? r_val + w_sample : w_sample;
            r_timer   <= '0;
            r_section <= SECTION_B;
          end else if (w_timeout_hit) begin
            r_ch    <= w_ch_next;
            r_timer <= '0;
            r_err   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        SECTION_B: begin
          r_out       <= r_val;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_ch        <= w_ch_next;
          r_section   <= SECTION_A;
        end
        default: r_section <= SECTION_A;
      endcase
    end
  end

  assign s_out       = r_out;
  assign s_out_valid = r_out_valid;
  assign s_out_ch    = r_out_ch;
  assign timeout_err = r_err;
  assign section     = r_section;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_master_slave_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multi_channel_master_slave_sampler                                    |
// | Three configurations (plain, timeout=4, accumulate) on shared stimulus.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_multi_channel_master_slave_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_in = '0;
  logic [1:0]  s_in_sync = '0;
  logic        err_clr = 1'b0;

  logic [31:0] out_v [3];
  logic        val_v [3];
  logic [0:0]  och_v [3];
  logic        err_v [3];
  logic        sec_v [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_channel_master_slave_sampler #(.NUM_CH(2), .DATA_W(32), .RESET_VAL(1337), .ACCUM(0), .TIMEOUT(0)) u_plain (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .err_clr(err_clr),
    .s_out(out_v[0]), .s_out_valid(val_v[0]), .s_out_ch(och_v[0]), .timeout_err(err_v[0]), .section(sec_v[0]));

  multi_channel_master_slave_sampler #(.NUM_CH(2), .DATA_W(32), .RESET_VAL(1337), .ACCUM(0), .TIMEOUT(4)) u_tmo (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .err_clr(err_clr),
    .s_out(out_v[1]), .s_out_valid(val_v[1]), .s_out_ch(och_v[1]), .timeout_err(err_v[1]), .section(sec_v[1]));

  multi_channel_master_slave_sampler #(.NUM_CH(2), .DATA_W(32), .RESET_VAL(1337), .ACCUM(1), .TIMEOUT(0)) u_acc (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .err_clr(err_clr),
    .s_out(out_v[2]), .s_out_valid(val_v[2]), .s_out_ch(och_v[2]), .timeout_err(err_v[2]), .section(sec_v[2]));

  // Reference model: "which channel am I waiting on, for how long, and is a publish pending".
  int          cfg_tmo [3] = '{0, 4, 0};
  bit          cfg_acc [3] = '{0, 0, 1};
  bit          m_pending [3];
  int          m_wait_ch [3];
  int          m_waited [3];
  logic [31:0] m_acc [3];
  logic [31:0] m_out [3];
  int          m_och [3];
  bit          m_valid [3];
  bit          m_err [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pending[i] = 0; m_wait_ch[i] = 0; m_waited[i] = 0;
        m_acc[i] = 32'd1337; m_out[i] = 32'd1337; m_och[i] = 0;
        m_valid[i] = 0; m_err[i] = 0;
      end else begin
        bit skipped;
        skipped = 0;
        m_valid[i] = 0;
        if (m_pending[i]) begin
          m_out[i] = m_acc[i];
          m_och[i] = m_wait_ch[i];
          m_valid[i] = 1;
          m_wait_ch[i] = (m_wait_ch[i] + 1) % 2;
          m_pending[i] = 0;
        end else if (s_in_sync[m_wait_ch[i]]) begin
          logic [31:0] d;
          d = (m_wait_ch[i] == 0) ? s_in[31:0] : s_in[63:32];
          m_acc[i] = cfg_acc[i] ? m_acc[i] + d : d;
          m_waited[i] = 0;
          m_pending[i] = 1;
        end else if (cfg_tmo[i] != 0) begin
          m_waited[i]++;
          if (m_waited[i] == cfg_tmo[i]) begin
            m_wait_ch[i] = (m_wait_ch[i] + 1) % 2;
            m_waited[i] = 0;
            skipped = 1;
          end
        end
        if (skipped) m_err[i] = 1;
        else if (err_clr) m_err[i] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_in_sync = '0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_v[i] !== 32'd1337 || val_v[i] !== 1'b0 || och_v[i] !== 1'b0 ||
          sec_v[i] !== 1'b0 || err_v[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got out=%0d valid=%b ch=%b sec=%b err=%b, expected out=1337 valid=0 ch=0 sec=0 err=0",
                 i, out_v[i], val_v[i], och_v[i], sec_v[i], err_v[i]);
      end
    end
  endtask

  task automatic test_sample();
    do_reset();
    s_in = {32'd0, 32'd5}; s_in_sync = 2'b01;
    tick();
    s_in_sync = 2'b00;
    n_cmp++;
    if (val_v[0] !== 1'b0 || sec_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL sample_latency: got valid=%b sec=%b, expected valid=0 sec=1", val_v[0], sec_v[0]);
    end
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b1 || out_v[0] !== 32'd5 || och_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL sample_ch0: got valid=%b out=%0d ch=%b, expected valid=1 out=5 ch=0", val_v[0], out_v[0], och_v[0]);
    end
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b0 || out_v[0] !== 32'd5) begin
      n_fail++; $display("FAIL sample_hold: got valid=%b out=%0d, expected valid=0 out=5", val_v[0], out_v[0]);
    end
    s_in = {32'd9, 32'd0}; s_in_sync = 2'b10;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b1 || out_v[0] !== 32'd9 || och_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL sample_ch1: got valid=%b out=%0d ch=%b, expected valid=1 out=9 ch=1", val_v[0], out_v[0], och_v[0]);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    s_in = {32'd7, 32'd0}; s_in_sync = 2'b10;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b0 || sec_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_other: got valid=%b sec=%b, expected valid=0 sec=0", val_v[0], sec_v[0]);
    end
    s_in = {32'd0, 32'd3}; s_in_sync = 2'b01;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b1 || out_v[0] !== 32'd3 || och_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_then_ch0: got valid=%b out=%0d ch=%b, expected valid=1 out=3 ch=0", val_v[0], out_v[0], och_v[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(); tick(); tick();
    n_cmp++;
    if (err_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got err=%b, expected 0", err_v[1]);
    end
    tick();
    n_cmp++;
    if (err_v[1] !== 1'b1 || val_v[1] !== 1'b0 || sec_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: got err=%b valid=%b sec=%b, expected err=1 valid=0 sec=0", err_v[1], val_v[1], sec_v[1]);
    end
    s_in = {32'd8, 32'd0}; s_in_sync = 2'b10;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[1] !== 1'b1 || out_v[1] !== 32'd8 || och_v[1] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_next_ch: got valid=%b out=%0d ch=%b, expected valid=1 out=8 ch=1", val_v[1], out_v[1], och_v[1]);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got err=%b, expected 0", err_v[1]);
    end
  endtask

  task automatic test_timeout_boundary();
    // Sync arriving on the expiry cycle is sampled without error.
    do_reset();
    tick(); tick(); tick();
    s_in = {32'd0, 32'd44}; s_in_sync = 2'b01;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (err_v[1] !== 1'b0 || val_v[1] !== 1'b1 || out_v[1] !== 32'd44 || och_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sync_wins: got err=%b valid=%b out=%0d ch=%b, expected err=0 valid=1 out=44 ch=0",
                         err_v[1], val_v[1], out_v[1], och_v[1]);
    end
    // Set beats clear when both land on the same edge.
    do_reset();
    tick(); tick(); tick(); tick();
    tick(); tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_v[1] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_set_wins: got err=%b, expected 1", err_v[1]);
    end
  endtask

  task automatic test_accumulate();
    do_reset();
    s_in = {32'd0, 32'd10}; s_in_sync = 2'b01;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[2] !== 1'b1 || out_v[2] !== 32'd1347) begin
      n_fail++; $display("FAIL accum_add: got valid=%b out=%0d, expected valid=1 out=1347", val_v[2], out_v[2]);
    end
    s_in = {32'hFFFF_FFFF, 32'd0}; s_in_sync = 2'b10;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[2] !== 1'b1 || out_v[2] !== 32'd1346 || och_v[2] !== 1'b1) begin
      n_fail++; $display("FAIL accum_wrap: got valid=%b out=%0d ch=%b, expected valid=1 out=1346 ch=1", val_v[2], out_v[2], och_v[2]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_in = {32'd0, 32'd11}; s_in_sync = 2'b01;
    tick();
    s_in_sync = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (val_v[0] !== 1'b0 || out_v[0] !== 32'd1337 || sec_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got valid=%b out=%0d sec=%b, expected valid=0 out=1337 sec=0", val_v[0], out_v[0], sec_v[0]);
    end
    s_in = {32'd22, 32'd21}; s_in_sync = 2'b11;
    tick();
    s_in_sync = 2'b00;
    tick();
    n_cmp++;
    if (val_v[0] !== 1'b1 || out_v[0] !== 32'd21 || och_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ch0: got valid=%b out=%0d ch=%b, expected valid=1 out=21 ch=0", val_v[0], out_v[0], och_v[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      s_in      = {$urandom(), $urandom()};
      s_in_sync = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (out_v[i] !== m_out[i] || val_v[i] !== m_valid[i] || och_v[i] !== 1'(m_och[i]) ||
            err_v[i] !== m_err[i] || sec_v[i] !== m_pending[i]) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: got out=%h v=%b ch=%b err=%b sec=%b, expected out=%h v=%b ch=%0d err=%b sec=%b",
                   i, c, out_v[i], val_v[i], och_v[i], err_v[i], sec_v[i],
                   m_out[i], m_valid[i], m_och[i], m_err[i], m_pending[i]);
        end
      end
    end
    rst = 1'b0; err_clr = 1'b0; s_in_sync = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sample();
    test_ignore();
    test_timeout();
    test_timeout_boundary();
    test_accumulate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
